// File: rtl/enemy_hit_judge.sv
// enemy_hit_judge: bullet/enemy overlap test, hit handshake with the bullet
// stage, ALIVE/FLASH/DEAD life cycle, kill score and sprite pixel enable.
// Build macro ENEMY_HP_EN: multi-hit enemy with HP_MAX hit points and a FLASH
// window after each non-fatal hit. Without it every accepted hit kills.
module enemy_hit_judge #(
    parameter int EW            = 46,
    parameter int EH            = 40,
    parameter int BW            = 10,
    parameter int BH            = 40,
    parameter int HP_MAX        = 3,
    parameter int FLASH_TICKS   = 8,
    parameter int RESPAWN_TICKS = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic [9:0]  b_x,
    input  logic [9:0]  b_y,
    input  logic        mybullet_exist,
    input  logic [9:0]  e_x,
    input  logic [9:0]  e_y,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    output logic        collide,
    output logic        enemy_en,
    output logic        enemy_alive,
    output logic [15:0] score,
    output logic        hit_pulse
);

    typedef enum logic [1:0] {
        ALIVE = 2'd0,
        FLASH = 2'd1,
        DEAD  = 2'd2
    } state_t;

    // One down-counter serves both the flash and the respawn timers; it is
    // at least 2 bits wide because bit 1 drives the flash blink.
    localparam int CNT_MAX = (FLASH_TICKS > RESPAWN_TICKS) ? FLASH_TICKS : RESPAWN_TICKS;
    localparam int CW      = ($clog2(CNT_MAX + 1) < 2) ? 2 : $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] RESPAWN_LOAD = CW'(RESPAWN_TICKS);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);
    localparam logic [10:0]   Y_OFF        = 11'd480;
    localparam logic [10:0]   EW11         = 11'(EW);
    localparam logic [10:0]   EH11         = 11'(EH);
    localparam logic [10:0]   BW11         = 11'(BW);
    localparam logic [10:0]   BH11         = 11'(BH);

    if (HP_MAX < 1) begin : g_bad_hp_max
        $error("enemy_hit_judge: HP_MAX must be at least 1");
    end

    // Coordinates widened to 11 bits so the +480 offset and sprite sizes never wrap.
    logic [10:0] bx, by, ex, ey, px, py;
    assign bx = {1'b0, b_x};
    assign by = {1'b0, b_y};
    assign ex = {1'b0, e_x};
    assign ey = {1'b0, e_y};
    assign px = {1'b0, x};
    assign py = {1'b0, y};

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          collide_q, collide_d;
    logic          hit_pulse_q, hit_pulse_d;
    logic [15:0]   score_q, score_d;

`ifdef ENEMY_HP_EN
    localparam int            HW           = ($clog2(HP_MAX + 1) < 1) ? 1 : $clog2(HP_MAX + 1);
    localparam logic [HW-1:0] HP_LOAD      = HW'(HP_MAX);
    localparam logic [HW-1:0] HP_ONE       = HW'(1);
    localparam logic [CW-1:0] FLASH_LOAD   = CW'(FLASH_TICKS);
    logic [HW-1:0] hp_q, hp_d;
`endif

    logic overlap;
    logic hit_acc;
    logic kill;

    // Bullet y is in the offset frame, so the enemy box is shifted by 480 too;
    // a bullet at or above 480 is still off-screen and never collides.
    assign overlap = (bx < ex + EW11) &&
                     (ex < bx + BW11) &&
                     (by < ey + Y_OFF + EH11) &&
                     (ey + Y_OFF < by + BH11) &&
                     (by > Y_OFF);

    // A hit counts only against a vulnerable enemy and while the previous
    // bullet has been released (collide high).
    assign hit_acc = overlap && mybullet_exist && collide_q && (state_q == ALIVE);

`ifdef ENEMY_HP_EN
    assign kill = hit_acc && (hp_q <= HP_ONE);
`else
    assign kill = hit_acc;
`endif

    // Bullet handshake: drop collide on a hit, release it once the bullet is gone.
    always_comb begin
        // NOTE: every always_comb output gets its default first, so no latch is inferred.
        collide_d   = collide_q;
        hit_pulse_d = hit_acc;
        if (hit_acc) begin
            collide_d = 1'b0;
        end else if (!collide_q && !mybullet_exist) begin
            collide_d = 1'b1;
        end
    end

    // Life-cycle next state: hits in ALIVE, tick-driven timers in FLASH and DEAD.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        score_d = score_q;
`ifdef ENEMY_HP_EN
        hp_d    = hp_q;
`endif
        unique case (state_q)
            ALIVE: begin
                // Ticks are ignored here, so a tick landing on the entry cycle
                // cannot shorten the freshly loaded timer.
                if (kill) begin
                    state_d = DEAD;
                    cnt_d   = RESPAWN_LOAD;
                    if (score_q != 16'hFFFF) begin
                        score_d = score_q + 16'd1;
                    end
                end
`ifdef ENEMY_HP_EN
                if (hit_acc) begin
                    hp_d = hp_q - HP_ONE;
                    if (!kill) begin
                        state_d = FLASH;
                        cnt_d   = FLASH_LOAD;
                    end
                end
`endif
            end
            FLASH: begin
                if (tick) begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q <= CNT_ONE) begin
                        cnt_d   = '0;
                        state_d = ALIVE;
                    end
                end
            end
            DEAD: begin
                if (tick) begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q <= CNT_ONE) begin
                        cnt_d   = '0;
                        state_d = ALIVE;
`ifdef ENEMY_HP_EN
                        hp_d    = HP_LOAD;
`endif
                    end
                end
            end
            default: begin
                state_d = ALIVE;
                cnt_d   = '0;
            end
        endcase
    end

    // State register with synchronous reset taking priority over hits and ticks.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= ALIVE;
            cnt_q       <= '0;
            collide_q   <= 1'b1;
            hit_pulse_q <= 1'b0;
            score_q     <= '0;
`ifdef ENEMY_HP_EN
            hp_q        <= HP_LOAD;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            collide_q   <= collide_d;
            hit_pulse_q <= hit_pulse_d;
            score_q     <= score_d;
`ifdef ENEMY_HP_EN
            hp_q        <= hp_d;
`endif
        end
    end

    assign collide     = collide_q;
    assign hit_pulse   = hit_pulse_q;
    assign score       = score_q;
    assign enemy_alive = (state_q != DEAD);

    // Sprite is drawn solid while ALIVE and blinks on counter bit 1 while FLASH.
    assign enemy_en = (px >= ex) && (px < ex + EW11) &&
                      (py >= ey) && (py < ey + EH11) &&
                      ((state_q == ALIVE) || ((state_q == FLASH) && cnt_q[1]));

endmodule

// File: tb/tb_enemy_hit_judge.sv
// Testbench for enemy_hit_judge: boundary vector table, hand-written hit,
// release, kill/respawn and reset sequences, then randomized traffic against
// a rule-level reference model. Honours ENEMY_HP_EN like the design.
module tb_enemy_hit_judge;

    localparam int EW            = 46;
    localparam int EH            = 40;
    localparam int BW            = 10;
    localparam int BH            = 40;
    localparam int HP_MAX        = 3;
    localparam int FLASH_TICKS   = 8;
    localparam int RESPAWN_TICKS = 60;
`ifdef ENEMY_HP_EN
    localparam int HP = HP_MAX;
`else
    localparam int HP = 1;
`endif

    localparam int PH_ALIVE = 0;
    localparam int PH_FLASH = 1;
    localparam int PH_DEAD  = 2;

    logic        clk = 1'b0;
    logic        rst, tick, mybullet_exist;
    logic [9:0]  b_x, b_y, e_x, e_y, x, y;
    logic        collide, enemy_en, enemy_alive, hit_pulse;
    logic [15:0] score;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    int m_phase, m_hp, m_timer, m_score;
    bit m_collide, m_pulse;

    typedef struct {
        int    bx, by, ex, ey;
        bit    exist;
        bit    hit;
        string name;
    } vec_t;
    vec_t vecs[$];

    enemy_hit_judge #(
        .EW(EW), .EH(EH), .BW(BW), .BH(BH), .HP_MAX(HP_MAX),
        .FLASH_TICKS(FLASH_TICKS), .RESPAWN_TICKS(RESPAWN_TICKS)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick),
        .b_x(b_x), .b_y(b_y), .mybullet_exist(mybullet_exist),
        .e_x(e_x), .e_y(e_y), .x(x), .y(y),
        .collide(collide), .enemy_en(enemy_en), .enemy_alive(enemy_alive),
        .score(score), .hit_pulse(hit_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, n_pass=%0d n_total=%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    function automatic bit overlap_f(int bx, int by, int ex, int ey);
        return (bx < ex + EW) && (ex < bx + BW) &&
               (by < ey + 480 + EH) && (ey + 480 < by + BH) && (by > 480);
    endfunction

    function automatic bit exp_en();
        bit in_box, visible;
        in_box  = (int'(x) >= int'(e_x)) && (int'(x) < int'(e_x) + EW) &&
                  (int'(y) >= int'(e_y)) && (int'(y) < int'(e_y) + EH);
        visible = (m_phase == PH_ALIVE) || ((m_phase == PH_FLASH) && ((m_timer / 2) % 2 == 1));
        return in_box && visible;
    endfunction

    function automatic int clamp10(int v);
        if (v < 0) return 0;
        if (v > 1023) return 1023;
        return v;
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic m_clock();
        bit acc;
        if (rst) begin
            m_phase = PH_ALIVE; m_hp = HP; m_timer = 0;
            m_collide = 1'b1; m_pulse = 1'b0; m_score = 0;
            return;
        end
        acc = overlap_f(int'(b_x), int'(b_y), int'(e_x), int'(e_y)) &&
              mybullet_exist && m_collide && (m_phase == PH_ALIVE);
        m_pulse = acc;
        if (acc) m_collide = 1'b0;
        else if (!m_collide && !mybullet_exist) m_collide = 1'b1;
        case (m_phase)
            PH_ALIVE: if (acc) begin
                m_hp = m_hp - 1;
                if (m_hp == 0) begin
                    m_phase = PH_DEAD; m_timer = RESPAWN_TICKS;
                    if (m_score < 65535) m_score = m_score + 1;
                end else begin
                    m_phase = PH_FLASH; m_timer = FLASH_TICKS;
                end
            end
            PH_FLASH: if (tick) begin
                m_timer = m_timer - 1;
                if (m_timer == 0) m_phase = PH_ALIVE;
            end
            default: if (tick) begin
                m_timer = m_timer - 1;
                if (m_timer == 0) begin m_phase = PH_ALIVE; m_hp = HP; end
            end
        endcase
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic check_outputs(input string tag);
        #1;
        check({tag, " collide"},     32'(collide),     32'(m_collide));
        check({tag, " hit_pulse"},   32'(hit_pulse),   32'(m_pulse));
        check({tag, " enemy_alive"}, 32'(enemy_alive), 32'(m_phase != PH_DEAD));
        check({tag, " score"},       32'(score),       32'(m_score));
        check({tag, " enemy_en"},    32'(enemy_en),    32'(exp_en()));
    endtask

    task automatic cycle();
        @(posedge clk);
        m_clock();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; tick = 1'b0; mybullet_exist = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    // Fire one bullet into the enemy, then retire it so collide is released.
    task automatic hit_once(input bit with_tick, input string tag);
        mybullet_exist = 1'b1; tick = with_tick;
        cycle();
        check_outputs({tag, " hit"});
        check({tag, " pulse"}, 32'(hit_pulse), 32'd1);
        mybullet_exist = 1'b0; tick = 1'b0;
        cycle();
        check_outputs({tag, " release"});
        check({tag, " collide back"}, 32'(collide), 32'd1);
    endtask

    task automatic give_ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            cycle();
            tick = 1'b0;
            cycle();
            check_outputs(tag);
        end
    endtask

    // Take the enemy from full hp to DEAD; optionally keep the last bullet alive.
    task automatic kill_enemy(input bit hold_last);
        for (int k = 0; k < HP - 1; k++) begin
            hit_once(1'b0, "kill");
            give_ticks(FLASH_TICKS, "kill flash");
        end
        mybullet_exist = 1'b1; tick = 1'b0;
        cycle();
        check_outputs("kill last");
        if (!hold_last) begin
            mybullet_exist = 1'b0;
            cycle();
            check_outputs("kill release");
        end
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; mybullet_exist = 1'b0;
        b_x = '0; b_y = '0; e_x = 10'd100; e_y = 10'd200; x = '0; y = '0;
        m_phase = PH_ALIVE; m_hp = HP; m_timer = 0; m_collide = 1'b1; m_pulse = 1'b0; m_score = 0;

        // Reset state
        cycle();
        rst = 1'b0;
        check_outputs("reset");
        check("reset collide", 32'(collide), 32'd1);
        check("reset score", 32'(score), 32'd0);
        check("reset alive", 32'(enemy_alive), 32'd1);

        // Overlap boundaries, one fresh enemy per vector
        vecs.push_back('{100,  700,  90, 200, 1'b1, 1'b1, "basic"});
        vecs.push_back('{146,  700, 100, 200, 1'b1, 1'b0, "x_right_edge"});
        vecs.push_back('{145,  700, 100, 200, 1'b1, 1'b1, "x_right_in"});
        vecs.push_back('{80,   700,  90, 200, 1'b1, 1'b0, "x_left_edge"});
        vecs.push_back('{81,   700,  90, 200, 1'b1, 1'b1, "x_left_in"});
        vecs.push_back('{100,  720,  90, 200, 1'b1, 1'b0, "y_bottom_edge"});
        vecs.push_back('{100,  719,  90, 200, 1'b1, 1'b1, "y_bottom_in"});
        vecs.push_back('{100,  640,  90, 200, 1'b1, 1'b0, "y_top_edge"});
        vecs.push_back('{100,  641,  90, 200, 1'b1, 1'b1, "y_top_in"});
        vecs.push_back('{100,  480,  90,   0, 1'b1, 1'b0, "offscreen"});
        vecs.push_back('{100,  481,  90,   0, 1'b1, 1'b1, "onscreen"});
        vecs.push_back('{100,  700,  90, 200, 1'b0, 1'b0, "no_exist"});
        vecs.push_back('{1010, 1000, 1000, 1000, 1'b1, 1'b0, "no_wrap"});
        vecs.push_back('{1020, 1023, 1000, 520, 1'b1, 1'b1, "high_corner"});
        foreach (vecs[i]) begin
            do_reset();
            b_x = 10'(vecs[i].bx); b_y = 10'(vecs[i].by);
            e_x = 10'(vecs[i].ex); e_y = 10'(vecs[i].ey);
            mybullet_exist = vecs[i].exist;
            cycle();
            check_outputs(vecs[i].name);
            check({vecs[i].name, " pulse_tbl"},   32'(hit_pulse), 32'(vecs[i].hit));
            check({vecs[i].name, " collide_tbl"}, 32'(collide),   32'(!vecs[i].hit));
        end

        // Hit, hold the bullet, then release it
        do_reset();
        e_x = 10'd90; e_y = 10'd200; b_x = 10'd100; b_y = 10'd700; x = 10'd95; y = 10'd205;
        mybullet_exist = 1'b1;
        cycle();
        check_outputs("hold hit");
        check("hold pulse", 32'(hit_pulse), 32'd1);
        check("hold collide", 32'(collide), 32'd0);
        check("hold alive", 32'(enemy_alive), 32'(HP > 1));
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_outputs("hold");
            check("hold collide low", 32'(collide), 32'd0);
            check("hold no pulse", 32'(hit_pulse), 32'd0);
        end
        mybullet_exist = 1'b0;
        cycle();
        check_outputs("hold release");
        check("hold collide high", 32'(collide), 32'd1);
        mybullet_exist = 1'b1;
        cycle();
        check_outputs("hold immune");
        check("hold immune pulse", 32'(hit_pulse), 32'd0);
        check("hold immune collide", 32'(collide), 32'd1);

        // Full kill with ticks on every hit cycle, then respawn
        do_reset();
        e_x = 10'd100; e_y = 10'd200; b_x = 10'd110; b_y = 10'd700; x = 10'd110; y = 10'd210;
        for (int k = 0; k < HP - 1; k++) begin
            hit_once(1'b1, "seq");
            give_ticks(FLASH_TICKS - 1, "seq flash");
            give_ticks(1, "seq flash end");
            check("seq flash over", 32'(enemy_en), 32'd1);
        end
        hit_once(1'b1, "seq kill");
        check("seq score", 32'(score), 32'd1);
        check("seq dead", 32'(enemy_alive), 32'd0);
        for (int i = 0; i < RESPAWN_TICKS - 1; i++) begin
            tick = 1'b1;
            cycle();
            tick = 1'b0;
            cycle();
            check_outputs("seq dead");
            check("seq dead en", 32'(enemy_en), 32'd0);
        end
        check("seq still dead", 32'(enemy_alive), 32'd0);
        give_ticks(1, "seq respawn");
        check("seq respawned", 32'(enemy_alive), 32'd1);
        check("seq respawn en", 32'(enemy_en), 32'd1);

        // Five kills, reset while DEAD with a held bullet, tick and overlap
        do_reset();
        for (int k = 0; k < 5; k++) begin
            kill_enemy(k == 4);
            if (k < 4) give_ticks(RESPAWN_TICKS, "multi respawn");
        end
        check("multi score", 32'(score), 32'd5);
        check("multi collide held", 32'(collide), 32'd0);
        rst = 1'b1; tick = 1'b1; mybullet_exist = 1'b1;
        cycle();
        rst = 1'b0; tick = 1'b0;
        check_outputs("dead reset");
        check("dead reset alive", 32'(enemy_alive), 32'd1);
        check("dead reset score", 32'(score), 32'd0);
        check("dead reset collide", 32'(collide), 32'd1);
        check("dead reset pulse", 32'(hit_pulse), 32'd0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if (i % 64 == 0) begin
                e_x = 10'($urandom_range(0, 1023));
                e_y = 10'($urandom_range(0, 1023));
            end
            rst            = ($urandom_range(0, 299) == 0);
            tick           = 1'($urandom_range(0, 1));
            mybullet_exist = ($urandom_range(0, 3) != 0);
            b_x = 10'(clamp10(int'(e_x) + int'($urandom_range(0, 70)) - 15));
            b_y = 10'(clamp10(int'(e_y) + 480 + int'($urandom_range(0, 100)) - 50));
            x   = 10'(clamp10(int'(e_x) + int'($urandom_range(0, 60)) - 5));
            y   = 10'(clamp10(int'(e_y) + int'($urandom_range(0, 50)) - 5));
            cycle();
            check_outputs("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/enemy_hit_judge.md
ENEMY_HIT_JUDGE -- requirements
Module: enemy_hit_judge

Interface
REQ-001 Parameter EW, 46, enemy sprite width in pixels.
REQ-002 Parameter EH, 40, enemy sprite height in pixels.
REQ-003 Parameter BW / BH, 10 / 40, player-bullet width / height in pixels.
REQ-004 Parameter HP_MAX, 3, enemy hit points (used only with ENEMY_HP_EN).
REQ-005 Parameter FLASH_TICKS / RESPAWN_TICKS, 8 / 60, tick counts for flash and respawn.
REQ-006 clk  in  1  system clock; all logic single-clock, rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 tick  in  1  one-cycle timing pulse (frame/move rate).
REQ-009 b_x, b_y  in  10 each  bullet top-left; b_y carries +480 offset (screen y = b_y-480).
REQ-010 mybullet_exist  in  1  1 = bullet live and collidable.
REQ-011 e_x, e_y  in  10 each  enemy top-left, plain screen coordinates.
REQ-012 x, y  in  10 each  current VGA scan pixel.
REQ-013 collide  out  1  active-low hit indication to bullet stage (0 = bullet consumed).
REQ-014 enemy_en  out  1  1 = scan pixel lies on visible enemy.
REQ-015 enemy_alive  out  1  1 = state ALIVE or FLASH.
REQ-016 score  out  16  kill counter.
REQ-017 hit_pulse  out  1  one-cycle pulse per accepted hit.

Function
REQ-018 Overlap SHALL be computed in 11-bit unsigned arithmetic, no wrap: b_x < e_x+EW and e_x < b_x+BW and b_y < e_y+480+EH and e_y+480 < b_y+BH and b_y > 480.
REQ-019 Hit SHALL be accepted when overlap and mybullet_exist and collide==1 and state==ALIVE.
REQ-020 collide SHALL go 0 the cycle after hit acceptance and stay 0 until mybullet_exist is sampled 0, then return to 1 the next cycle.
REQ-021 While collide==0 no further hit SHALL be accepted.
REQ-022 FSM states ALIVE, FLASH, DEAD; hit in FLASH or DEAD SHALL be ignored (collide stays 1).
REQ-023 ALIVE, hit accepted: hp decrements; hp becomes 0 -> DEAD, load respawn counter; else -> FLASH, load flash counter.
REQ-024 FLASH: counter decrements on each tick; reaching 0 -> ALIVE.
REQ-025 DEAD: counter decrements on each tick; reaching 0 -> ALIVE with hp = HP_MAX.
REQ-026 tick in ALIVE SHALL have no effect; tick coincident with state entry SHALL not decrement the freshly loaded counter.
REQ-027 score SHALL increment by 1 on each transition into DEAD, saturating at 16'hFFFF.
REQ-028 hit_pulse SHALL be high exactly one cycle, the same cycle collide first goes 0.
REQ-029 enemy_en SHALL be combinational: x in [e_x, e_x+EW), y in [e_y, e_y+EH), and (ALIVE, or FLASH with flash counter bit 1 == 1); 0 in DEAD.
REQ-030 Hit latency: overlap at cycle N -> collide low, hit_pulse high, state update at cycle N+1.

Reset
REQ-031 rst==1 at a clock edge SHALL force state ALIVE, hp = HP_MAX (1 without ENEMY_HP_EN), counters 0, collide 1, hit_pulse 0, score 0, regardless of current state.
REQ-032 rst SHALL take priority over tick and hit in the same cycle.

Configuration
REQ-033 Macro ENEMY_HP_EN defined: hp register of HP_MAX width, FLASH state reachable.
REQ-034 ENEMY_HP_EN undefined: hp fixed 1, every accepted hit -> DEAD, FLASH never entered, no hp register.

Verification
REQ-035 Reset, then b_x=100,b_y=700,e_x=90,e_y=200,exist=1 -> next cycle collide=0, hit_pulse=1; with ENEMY_HP_EN state FLASH, hp=2.
REQ-036 Hold collide low, drop exist to 0 after 5 cycles -> collide returns 1 one cycle after exist sampled 0; no second hit_pulse.
REQ-037 ENEMY_HP_EN, three separated hits (each after FLASH expires, 8 ticks) -> DEAD after third, score 0->1; enemy_en=0 for 60 ticks, then ALIVE.
REQ-038 Edge: b_x = e_x+EW (146 vs e_x=100) -> no hit; b_x = e_x+EW-1 -> hit.
REQ-039 b_y=480 with overlapping x -> no hit (bullet off-screen).
REQ-040 Assert rst during DEAD with score=5 -> next cycle ALIVE, score 0, collide 1.
